glyph_rom_arbiter: RTL

//  Round-robin arbiter sharing one combinational 10-digit glyph ROM (5x5 digits, 8-bit row word)

---
 rtl/glyph_rom_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/glyph_rom_arbiter.sv
// glyph_rom_arbiter: round-robin arbiter sharing one combinational 5x5 digit
// glyph ROM between NREQ text/score renderers in the pixel clock domain.
// Stage 1 registers the winning address to the ROM; stage 2 registers the
// returned row and tags it back to the requester (2-cycle accept-to-data).
// Optional feature macro: GLYPH_ARB_BURST_EN (locked requesters keep priority
// for up to BURST_MAX consecutive grants).
module glyph_rom_arbiter #(
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [4*NREQ-1:0]    req_digit,
    input  logic [3*NREQ-1:0]    req_yofs,
    input  logic [NREQ-1:0]      req_lock,
    output logic [NREQ-1:0]      ack,
    output logic [3:0]           rom_digit,
    output logic [2:0]           rom_yofs,
    input  logic [7:0]           rom_bits,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [7:0]           rsp_bits,
    output logic                 err_range
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   win;
    logic [PW-1:0]   tag;
    logic            grant;
    logic            s1_valid;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] ack_nxt;
    logic [NREQ-1:0] rsp_oh;
    logic            range_bad;

`ifdef GLYPH_ARB_BURST_EN
    localparam int CW = $clog2(BURST_MAX + 1);

    // hold_r: the pointer was left on the last winner because it is bursting;
    // burst_left counts down the grants it may still take before rotation.
    logic            hold_r;
    logic            hold_nxt;
    logic [CW-1:0]   burst_left;
    logic [CW-1:0]   burst_left_nxt;
    logic [CW-1:0]   rem;
    logic            cont;
`else
    logic            lock_unused;
    assign lock_unused = (^req_lock) ^ (BURST_MAX > 0);
`endif

    // Eligible set, circular first-set-bit scan from the pointer, pointer update.
    always_comb begin
`ifdef GLYPH_ARB_BURST_EN
        elig = req & ~(ack & ~({NREQ{hold_r}} & req_lock));
`else
        elig = req & ~ack;
`endif
        grant = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant && elig[(int'(ptr) + k) % NREQ]) begin
                grant = 1'b1;
                win   = PW'((int'(ptr) + k) % NREQ);
            end
        end

        ack_nxt = '0;
        if (grant) begin
            ack_nxt[win] = 1'b1;
        end

        ptr_nxt = ptr;
        if (grant) begin
            ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        end

`ifdef GLYPH_ARB_BURST_EN
        hold_nxt       = hold_r;
        burst_left_nxt = burst_left;
        cont           = 1'b0;
        rem            = '0;
        if (grant) begin
            cont = hold_r && (win == ptr);
            rem  = cont ? (burst_left - CW'(1)) : CW'(BURST_MAX - 1);
            if (req_lock[win] && (rem != '0)) begin
                ptr_nxt        = win;
                hold_nxt       = 1'b1;
                burst_left_nxt = rem;
            end else begin
                hold_nxt       = 1'b0;
                burst_left_nxt = '0;
            end
        end
`endif
    end

`ifdef GLYPH_ARB_BURST_EN
    // Burst bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_r     <= 1'b0;
            burst_left <= '0;
        end else begin
            hold_r     <= hold_nxt;
            burst_left <= burst_left_nxt;
        end
    end
`endif

    // Stage 1: grant pulse, pointer, and registered ROM address with its tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack       <= '0;
            ptr       <= '0;
            rom_digit <= '0;
            rom_yofs  <= '0;
            tag       <= '0;
            s1_valid  <= 1'b0;
        end else begin
            ack      <= ack_nxt;
            ptr      <= ptr_nxt;
            s1_valid <= grant;
            if (grant) begin
                rom_digit <= req_digit[4*int'(win) +: 4];
                rom_yofs  <= req_yofs[3*int'(win) +: 3];
                tag       <= win;
            end
        end
    end

    assign range_bad = (rom_digit > 4'd9) || (rom_yofs > 3'd4);

    // One-hot response tag for the lookup currently in stage 1.
    always_comb begin
        rsp_oh = '0;
        if (s1_valid) begin
            rsp_oh[tag] = 1'b1;
        end
    end

    // Stage 2: capture the ROM row (zeroed for out-of-range addresses), sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_bits  <= '0;
            err_range <= 1'b0;
        end else begin
            rsp_valid <= rsp_oh;
            if (s1_valid) begin
                rsp_bits  <= range_bad ? 8'h00 : rom_bits;
                err_range <= err_range | range_bad;
            end
        end
    end

endmodule
